// File: rtl/nibble_serial_adder_seq.sv
// Multi-precision add/subtract sequencer feeding an external 4-bit combinational adder.
// Optional signed-overflow output is enabled by defining OVERFLOW_FLAG_EN.
module nibble_serial_adder_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH must be a multiple of 4 and at least 8.
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_add_cin;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_last;
    logic             w_consume;
    logic             w_ovf_nib;

    assign w_accept  = (r_state == S_IDLE) & in_valid;
    assign w_last    = (r_state == S_RUN) & (r_idx == LAST_IDX);
    assign w_consume = (r_state == S_DONE) & out_ready;
    assign w_ovf_nib = (r_a_sh[3] == r_b_sh[3]) & (add_sum[3] != r_a_sh[3]);

    // Shift registers empty themselves after N nibbles, so the adder
    // operands read zero outside RUN without extra gating.
    assign add_a     = r_a_sh[3:0];
    assign add_b     = r_b_sh[3:0];
    assign add_cin   = r_add_cin;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_res;
    assign cout      = r_carry;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_consume) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Operand capture, nibble shifting and result reassembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_add_cin <= 1'b0;
            r_res     <= '0;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh    <= op_a;
                        r_b_sh    <= sub ? ~op_b : op_b;
                        r_carry   <= sub ? 1'b1 : cin;
                        r_add_cin <= sub ? 1'b1 : cin;
                        r_idx     <= '0;
                    end else begin
                        r_a_sh    <= r_a_sh;
                    end
                end
                S_RUN: begin
                    r_res     <= {add_sum, r_res[WIDTH-1:4]};
                    r_carry   <= add_cout;
                    // add_cin mirrors the carry only while nibbles are in flight
                    r_add_cin <= w_last ? 1'b0 : add_cout;
                    r_a_sh    <= {4'd0, r_a_sh[WIDTH-1:4]};
                    r_b_sh    <= {4'd0, r_b_sh[WIDTH-1:4]};
                    r_idx     <= r_idx + IDX_W'(1);
                end
                S_DONE: begin
                    r_res     <= r_res;
                end
                default: begin
                    r_idx     <= '0;
                end
            endcase
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // Signed overflow taken from the top nibble of the post-inversion operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_ovf_nib;
        end else begin
            r_ovf <= r_ovf;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_ovf_nib;
`endif

endmodule

// File: doc/nibble_serial_adder_seq.md
# nibble_serial_adder_seq

Multi-precision add/subtract sequencer that sits directly upstream of the team's 4-bit ripple-carry adder. It accepts WIDTH-bit operands over a valid/ready handshake and streams them to the adder one nibble per cycle, LSB first, threading the carry between nibbles. It reassembles the WIDTH-bit result and presents it downstream with its own valid/ready handshake. The adder is external and purely combinational; this block drives its A/B/Cin inputs and consumes its Sum/Cout outputs in the same cycle.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibbles.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 = compute A − B (B inverted, carry-in forced to 1).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  sum/difference.
- cout  out  1  final carry out of nibble N−1 (for sub: 1 = no borrow).
- add_a  out  4  to adder A.
- add_b  out  4  to adder B.
- add_cin  out  1  to adder Cin.
- add_sum  in  4  from adder Sum.
- add_cout  in  1  from adder Cout.

## Operation
- FSM states: IDLE, RUN, DONE. Counter idx, log2(N) bits.
- IDLE: in_ready=1. On in_valid&in_ready: a_sh←op_a; b_sh←sub ? ~op_b : op_b; carry←sub ? 1 : cin; idx←0; → RUN.
- RUN: add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=carry. Each edge: res←{add_sum, res[WIDTH-1:4]}; carry←add_cout; a_sh, b_sh shift right 4; idx++. When idx==N−1 at the edge → DONE.
- DONE: out_valid=1, result=res, cout=carry, both held stable until out_valid&out_ready; then → IDLE.
- Outside RUN, add_a/add_b/add_cin drive 0.
- Operand inputs are sampled only on the accept edge; later changes are ignored.
- No overlap: a new request is not accepted in the same cycle a result is consumed.
- Reset (any state, including mid-RUN): state→IDLE, idx/carry/res/a_sh/b_sh→0. In-flight operation is discarded with no output.
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, add_a=0, add_b=0, add_cin=0. Signed overflow output, when present: 0.

## Timing
- Accept at edge E0. Nibble k is captured at edge E0+k+1, k=0..N−1.
- out_valid rises after edge E0+N (WIDTH=16 → 4 cycles).
- out_valid high with out_ready high → IDLE at that edge; in_ready high the following cycle.
- Minimum issue interval: N+2 cycles with out_ready held high.
- Adder path is combinational within one cycle: registered shift LSBs → adder → res/carry registers.
- out_ready low in DONE: stall indefinitely, outputs unchanged.

## Configuration
- OVERFLOW_FLAG_EN defined:
  - Adds output port ovf (1 bit, registered).
  - In the final RUN cycle, ovf←(add_a[3]==add_b[3]) & (add_sum[3]!=add_a[3]), evaluated on the post-inversion B.
  - Valid alongside result in DONE; reset/IDLE value 0.
- Not defined: no ovf port and no overflow logic; all other behaviour identical.

## Test plan
- Reset mid-RUN (WIDTH=16, assert rst after 2 nibbles) -> immediately in_ready=1, out_valid=0, result=0, add_*=0; next request completes normally.
- Add: op_a=0x1234, op_b=0x0FFF, cin=0 -> after 4 cycles out_valid=1, result=0x2233, cout=0; add_cin sequence per RUN cycle 0,1,1,1.
- Carry through all nibbles: op_a=0xFFFF, op_b=0x0000, cin=1 -> result=0x0000, cout=1.
- Subtract: sub=1, op_a=0x0005, op_b=0x0007 -> result=0xFFFE, cout=0; with op_a=0x0007, op_b=0x0005 -> result=0x0002, cout=1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result/cout stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle. Back-to-back with out_ready=1 -> 6-cycle interval.
- OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> result=0x8000, ovf=1; 0x8000−0x0001 -> result=0x7FFF, ovf=1; 0x0001+0x0001 -> ovf=0.
